// File: rtl/crc16_pkg.sv
// Shared types, widths and the single-bit LFSR update for the serial CRC-16 block.
package crc16_pkg;

    localparam int unsigned CRC_W            = 16;
    localparam logic [15:0] CRC16_CCITT_POLY = 16'h1021;
    localparam int unsigned CRC_OUT_CNT      = 16;
    localparam int unsigned CNT_W            = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        OUT
    } crc_state_e;

    // MSB-first Galois update; the x^16 term is implicit in the feedback.
    function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc,
                                                    input logic             din,
                                                    input logic [CRC_W-1:0] poly);
        logic fb;
        fb = crc[CRC_W-1] ^ din;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/crc_16_serial_if.sv
// Serial stream bundle between the data source, the CRC block and the line driver.
interface crc_16_serial_if;

    logic load;
    logic d_finish;
    logic crc_in;
    logic crc_out;

    modport master (
        output load,
        output d_finish,
        output crc_in,
        input  crc_out
    );

    modport slave (
        input  load,
        input  d_finish,
        input  crc_in,
        output crc_out
    );

endinterface

// File: rtl/crc16_lfsr_step.sv
// Combinational single-bit CRC-16 register update.
module crc16_lfsr_step
    import crc16_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC16_CCITT_POLY
) (
    input  logic [CRC_W-1:0] crc,
    input  logic             din,
    output logic [CRC_W-1:0] crc_next
);

    assign crc_next = crc16_step(crc, din, POLY);

endmodule

// File: rtl/crc_16_serial.sv
// Bit-serial CRC-16/XMODEM: echoes the message, then appends the CRC MSB-first.
// Define CRC16_SERIAL_XOROUT_EN to transmit the CRC inverted (crc ^ 16'hFFFF).
module crc_16_serial
    import crc16_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC16_CCITT_POLY,
    parameter logic [CRC_W-1:0] INIT = 16'h0000
) (
    input logic            clk,
    input logic            rst,
    crc_16_serial_if.slave bus
);

`ifdef CRC16_SERIAL_XOROUT_EN
    localparam logic XOR_OUT = 1'b1;
`else
    localparam logic XOR_OUT = 1'b0;
`endif

    crc_state_e       state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;
    logic [CRC_W-1:0] crc_step;
    logic [CRC_W-1:0] crc_shl;

    crc16_lfsr_step #(
        .POLY (POLY)
    ) u_step (
        .crc      (crc_q),
        .din      (bus.crc_in),
        .crc_next (crc_step)
    );

    // Shift-out only moves the register; nothing is absorbed after d_finish.
    assign crc_shl = {crc_q[CRC_W-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        cnt_d   = cnt_q;
        out_d   = 1'b0;
        if (bus.load) begin
            state_d = SHIFT;
            crc_d   = INIT;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                SHIFT: begin
                    if (bus.d_finish) begin
                        out_d   = crc_q[CRC_W-1] ^ XOR_OUT;
                        crc_d   = crc_shl;
                        cnt_d   = CNT_W'(1);
                        state_d = OUT;
                    end else begin
                        out_d = bus.crc_in;
                        crc_d = crc_step;
                    end
                end
                OUT: begin
                    if (cnt_q == CNT_W'(CRC_OUT_CNT)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        out_d = crc_q[CRC_W-1] ^ XOR_OUT;
                        crc_d = crc_shl;
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            crc_q   <= INIT;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign bus.crc_out = out_q;

endmodule

// File: tb/tb_crc_16_serial.sv
// Scoreboard bench for crc_16_serial: expected output bits are queued as stimulus is driven.
module tb_crc_16_serial;

`ifdef CRC16_SERIAL_XOROUT_EN
    localparam logic [15:0] XOR_MASK = 16'hFFFF;
`else
    localparam logic [15:0] XOR_MASK = 16'h0000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic exp_q[$];
    logic msg[$];

    crc_16_serial_if bus ();

    crc_16_serial dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Independent bitwise XMODEM reference over the bits absorbed in the current frame.
    function automatic logic [15:0] ref_crc();
        logic [15:0] c;
        c = 16'h0000;
        foreach (msg[i]) begin
            if (c[15] != msg[i]) c = (c << 1) ^ 16'h1021;
            else                 c = c << 1;
        end
        return c;
    endfunction

    task automatic cyc(input logic ld, input logic df, input logic din, input logic exp,
                       input string tag, output logic got);
        logic e;
        @(negedge clk);
        bus.load     = ld;
        bus.d_finish = df;
        bus.crc_in   = din;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        got = bus.crc_out;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, {31'd0, got}, {31'd0, e});
        end
    endtask

    task automatic start_frame(input logic with_finish);
        logic g;
        cyc(1'b1, with_finish, 1'($urandom), 1'b0, "load", g);
        msg.delete();
    endtask

    task automatic send(input logic b);
        logic g;
        cyc(1'b0, 1'b0, b, b, "echo", g);
        msg.push_back(b);
    endtask

    task automatic tail(input int nck, input logic hold, input logic fin_din,
                        output logic [15:0] word);
        logic [15:0] e;
        logic        g;
        e    = ref_crc() ^ XOR_MASK;
        word = '0;
        cyc(1'b0, 1'b1, fin_din, e[15], "crc_bit", g);
        word[15] = g;
        for (int i = 1; i < nck; i++) begin
            cyc(1'b0, hold, 1'($urandom), e[15-i], "crc_bit", g);
            word[15-i] = g;
        end
        if (nck == 16) begin
            cyc(1'b0, hold, 1'($urandom), 1'b0, "post_crc_idle", g);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] word;
        logic        g;
        string       s;
        logic [7:0]  c;

        bus.load     = 1'b0;
        bus.d_finish = 1'b0;
        bus.crc_in   = 1'b0;
        #12;
        check("reset_out", {31'd0, bus.crc_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // IDLE ignores d_finish and crc_in
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, "idle_dfin", g);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, "idle", g);

        // Single bit 1 -> 0x1021
        start_frame(1'b0);
        send(1'b1);
        tail(16, 1'b0, 1'b1, word);
        check("single_crc", {16'd0, word}, {16'd0, 16'h1021 ^ XOR_MASK});

        // "123456789" check value
        start_frame(1'b0);
        s = "123456789";
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            for (int b = 7; b >= 0; b--) send(c[b]);
        end
        tail(16, 1'b0, 1'b1, word);
        check("check_crc", {16'd0, word}, {16'd0, 16'h31C3 ^ XOR_MASK});

        // Alternating pairs, d_finish held through OUT and its bit excluded
        start_frame(1'b0);
        for (int i = 0; i < 80; i++) send(((i / 2) % 2) == 0);
        tail(16, 1'b1, 1'b1, word);
        check("alt_crc", {16'd0, word}, {16'd0, ref_crc() ^ XOR_MASK});

        // Restart during OUT after 5 CRC bits, then zero-length frame
        start_frame(1'b0);
        for (int b = 7; b >= 0; b--) send(((8'hA5 >> b) & 8'h1) != 0);
        tail(5, 1'b0, 1'b0, word);
        start_frame(1'b0);
        tail(16, 1'b0, 1'b1, word);
        check("zero_len_crc", {16'd0, word}, {16'd0, XOR_MASK});

        // load together with d_finish mid-SHIFT restarts the frame
        start_frame(1'b0);
        for (int b = 7; b >= 0; b--) send(((8'h3C >> b) & 8'h1) != 0);
        start_frame(1'b1);
        send(1'b1); send(1'b0); send(1'b1); send(1'b1);
        tail(16, 1'b0, 1'b0, word);
        check("collide_crc", {16'd0, word}, {16'd0, ref_crc() ^ XOR_MASK});

        // Asynchronous reset mid-frame
        start_frame(1'b0);
        for (int i = 0; i < 5; i++) send(1'b1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst_out", {31'd0, bus.crc_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.crc_in = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, "post_rst_idle", g);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, "post_rst_dfin", g);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, "post_rst_idle2", g);

        check("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
